sprite_position_ctrl: RTL and testbench

- Upstream control stage for the sprite multiplexer: turns raw board push-buttons into the sprite position (posX, posY) and the 2-bit sprite selector (contador_seleccionador) that the mux consumes.
- Buttons are synchronized and debounced. Movement is applied once per video frame, during vertical blanking, so a sprite never tears mid-frame.
- The selector cycles none -> sprite1 -> sprite2 -> none on each debounced press of the select key.

---
 rtl/sprite_position_ctrl_if.sv | 24 ++
 rtl/sprite_position_ctrl.sv | 144 ++++++++++++++
 tb/tb_sprite_position_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_position_ctrl_if.sv
// Button, VGA-counter and sprite-position signals shared between the board glue and
// the sprite position controller.
interface sprite_position_ctrl_if;
    logic       btn_izq;
    logic       btn_der;
    logic       btn_arr;
    logic       btn_aba;
    logic       btn_sel;
    logic [9:0] cuentaX;
    logic [9:0] cuentaY;
    logic [9:0] posX;
    logic [9:0] posY;
    logic [1:0] contador_seleccionador;

    modport master (
        output btn_izq, btn_der, btn_arr, btn_aba, btn_sel, cuentaX, cuentaY,
        input  posX, posY, contador_seleccionador
    );

    modport slave (
        input  btn_izq, btn_der, btn_arr, btn_aba, btn_sel, cuentaX, cuentaY,
        output posX, posY, contador_seleccionador
    );
endinterface

// File: rtl/sprite_position_ctrl.sv
// Debounced push-buttons move the sprite once per frame during vertical blanking and
// step the sprite selector none -> sprite1 -> sprite2 -> none on each select press.
module sprite_position_ctrl #(
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned SPRITE_W        = 64,
    parameter int unsigned SPRITE_H        = 64,
    parameter int unsigned STEP            = 4,
    parameter int unsigned X_INIT          = 288,
    parameter int unsigned Y_INIT          = 208,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input logic                   clk,
    input logic                   rst_n,
    sprite_position_ctrl_if.slave bus
);

    localparam int unsigned NumKeys = 5;
    localparam int unsigned KIzq    = 0;
    localparam int unsigned KDer    = 1;
    localparam int unsigned KArr    = 2;
    localparam int unsigned KAba    = 3;
    localparam int unsigned KSel    = 4;
    localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0]     XMax   = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0]     YMax   = 11'(SCREEN_H - SPRITE_H);
    localparam logic [10:0]     Step11 = 11'(STEP);

    typedef enum logic [1:0] {
        SelNone = 2'b00,
        SelS1   = 2'b01,
        SelS2   = 2'b10
    } sel_e;

    // Reset asserts asynchronously but releases only on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    logic [NumKeys-1:0]           key_pressed;
    logic [NumKeys-1:0]           sync1_q, sync2_q;
    logic [NumKeys-1:0]           deb_q, deb_d;
    logic [NumKeys-1:0][CntW-1:0] cnt_q, cnt_d;
    logic                         tick_q, tick_d;
    logic [9:0]                   posx_q, posx_d, posy_q, posy_d;
    sel_e                         sel_q, sel_d;

    assign key_pressed = ~{bus.btn_sel, bus.btn_aba, bus.btn_arr, bus.btn_der, bus.btn_izq};

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int k = 0; k < NumKeys; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CntMax) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CntW'(1);
                end
            end
        end
    end

    assign tick_d = (bus.cuentaX == 10'd0) && (bus.cuentaY == 10'(SCREEN_H));

    // 11-bit arithmetic: bit 10 of the decrement flags underflow below zero.
    logic [10:0] x_dec, x_inc, y_dec, y_inc;

    assign x_dec = {1'b0, posx_q} - Step11;
    assign x_inc = {1'b0, posx_q} + Step11;
    assign y_dec = {1'b0, posy_q} - Step11;
    assign y_inc = {1'b0, posy_q} + Step11;

    always_comb begin
        posx_d = posx_q;
        posy_d = posy_q;
        if (tick_q) begin
            if (deb_q[KIzq] && !deb_q[KDer]) begin
                posx_d = x_dec[10] ? 10'd0 : x_dec[9:0];
            end else if (deb_q[KDer] && !deb_q[KIzq]) begin
                posx_d = (x_inc > XMax) ? XMax[9:0] : x_inc[9:0];
            end
            if (deb_q[KArr] && !deb_q[KAba]) begin
                posy_d = y_dec[10] ? 10'd0 : y_dec[9:0];
            end else if (deb_q[KAba] && !deb_q[KArr]) begin
                posy_d = (y_inc > YMax) ? YMax[9:0] : y_inc[9:0];
            end
        end
    end

    logic sel_press;

    assign sel_press = deb_d[KSel] && !deb_q[KSel];

    always_comb begin
        sel_d = sel_q;
        if (sel_press) begin
            case (sel_q)
                SelNone: sel_d = SelS1;
                SelS1:   sel_d = SelS2;
                default: sel_d = SelNone;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            posx_q  <= 10'(X_INIT);
            posy_q  <= 10'(Y_INIT);
            sel_q   <= SelNone;
        end else begin
            sync1_q <= key_pressed;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.posX                   = posx_q;
    assign bus.posY                   = posy_q;
    assign bus.contador_seleccionador = sel_q;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Scoreboard bench for sprite_position_ctrl: expected positions are queued per driven
// frame tick and checked when the DUT updates; selector steps are queued per press.
module tb_sprite_position_ctrl;

    localparam int unsigned Deb       = 5000;
    localparam int unsigned FrameIdle = 8;
    localparam int          KIzq      = 0;
    localparam int          KDer      = 1;
    localparam int          KArr      = 2;
    localparam int          KAba      = 3;
    localparam int          KSel      = 4;
    localparam int          XLim      = 576;
    localparam int          YLim      = 416;

    typedef struct {
        int x;
        int y;
    } pos_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sprite_position_ctrl_if bus();

    sprite_position_ctrl #(
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [4:0] kb = '0;
    logic [4:0] hk = '0;
    logic       drv_tick = 1'b0;

    assign bus.btn_izq = ~kb[KIzq];
    assign bus.btn_der = ~kb[KDer];
    assign bus.btn_arr = ~kb[KArr];
    assign bus.btn_aba = ~kb[KAba];
    assign bus.btn_sel = ~kb[KSel];
    assign bus.cuentaX = drv_tick ? 10'd0 : 10'd5;
    assign bus.cuentaY = drv_tick ? 10'd480 : 10'd0;

    int   tests = 0;
    int   fails = 0;
    int   exp_x = 288, exp_y = 208, exp_sel = 0;
    int   cur_x = 288, cur_y = 208, cur_sel = 0;
    bit   mon_en = 1'b0;
    bit   tk1 = 1'b0, tk2 = 1'b0;
    pos_t pos_q[$];
    int   sel_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tick();
        pos_t p;
        if (hk[KIzq] && !hk[KDer]) exp_x = (exp_x < 4) ? 0 : exp_x - 4;
        else if (hk[KDer] && !hk[KIzq]) exp_x = (exp_x + 4 > XLim) ? XLim : exp_x + 4;
        if (hk[KArr] && !hk[KAba]) exp_y = (exp_y < 4) ? 0 : exp_y - 4;
        else if (hk[KAba] && !hk[KArr]) exp_y = (exp_y + 4 > YLim) ? YLim : exp_y + 4;
        p.x = exp_x;
        p.y = exp_y;
        pos_q.push_back(p);
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            drv_tick = 1'b1;
            push_tick();
            step();
            drv_tick = 1'b0;
            repeat (FrameIdle) step();
        end
    endtask

    // Changes raw keys and holds them until the debouncer has certainly accepted them.
    task automatic set_keys(input logic [4:0] m);
        if (m[KSel] && !hk[KSel]) begin
            exp_sel = (exp_sel == 0) ? 1 : (exp_sel == 1) ? 2 : 0;
            sel_q.push_back(exp_sel);
        end
        kb       = m;
        drv_tick = 1'b0;
        repeat (Deb + 4) step();
        hk = m;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            tk2 = tk1;
            tk1 = drv_tick;
        end
    end

    initial begin
        pos_t p;
        int   e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tk2) begin
                    check_eq("pos_pending", int'(pos_q.size() != 0), 1);
                    if (pos_q.size() != 0) begin
                        p = pos_q.pop_front();
                        check_eq("posX", int'(bus.posX), p.x);
                        check_eq("posY", int'(bus.posY), p.y);
                        cur_x = p.x;
                        cur_y = p.y;
                    end
                end else if (int'(bus.posX) != cur_x || int'(bus.posY) != cur_y) begin
                    check_eq("stray_posX", int'(bus.posX), cur_x);
                    check_eq("stray_posY", int'(bus.posY), cur_y);
                end
                if (int'(bus.contador_seleccionador) != cur_sel) begin
                    if (sel_q.size() == 0) begin
                        check_eq("sel_extra_step", int'(bus.contador_seleccionador), cur_sel);
                    end else begin
                        e = sel_q.pop_front();
                        check_eq("sel", int'(bus.contador_seleccionador), e);
                        cur_sel = e;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        rst_n = 1'b0;
        #21;
        check_eq("rst_posX", int'(bus.posX), 288);
        check_eq("rst_posY", int'(bus.posY), 208);
        check_eq("rst_sel", int'(bus.contador_seleccionador), 0);
        rst_n = 1'b1;
        repeat (5) step();
        mon_en = 1'b1;
        frame(3);

        // Bouncing right key: never stable long enough to be accepted.
        for (int c = 0; c < 20000; c++) begin
            kb[KDer] = ((c / 1000) % 2 == 0);
            if (c % 50 == 0) begin
                drv_tick = 1'b1;
                push_tick();
            end else begin
                drv_tick = 1'b0;
            end
            step();
        end
        drv_tick = 1'b0;
        kb       = '0;
        kb[KDer] = 1'b1;
        repeat (Deb) step();
        // Tick seen one cycle before acceptance must not move; the next one must.
        drv_tick = 1'b1;
        push_tick();
        step();
        hk = kb;
        push_tick();
        step();
        drv_tick = 1'b0;
        repeat (FrameIdle) step();

        frame(73);
        set_keys(5'b00100);
        frame(54);
        set_keys(5'b01011);
        frame(3);

        for (int i = 0; i < 4; i++) begin
            set_keys(5'b10001);
            frame(3);
            set_keys(5'b00001);
            frame(3);
        end
        check_eq("sel_pending", sel_q.size(), 0);
        frame(20);
        set_keys(5'b00010);
        check_eq("pos_q_drained", pos_q.size(), 0);
        check_eq("pre_rst_posX", exp_x, 400);

        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_posX", int'(bus.posX), 288);
        check_eq("async_rst_posY", int'(bus.posY), 208);
        check_eq("async_rst_sel", int'(bus.contador_seleccionador), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        hk      = '0;
        exp_x   = 288;
        exp_y   = 208;
        exp_sel = 0;
        cur_x   = 288;
        cur_y   = 208;
        cur_sel = 0;
        pos_q.delete();
        sel_q.delete();
        repeat (4) step();
        mon_en = 1'b1;
        frame(2);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
